// File: rtl/cube_pkg.sv
// Shared widths, iteration count and state encodings for the cube generator.
package cube_pkg;

  localparam int XW   = 8;
  localparam int YW   = 3 * XW;
  localparam int ITER = XW;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2
  } state_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_RUN  = 1'b1
  } mult_state_t;

endpackage

// File: rtl/cube_if.sv
// start/busy handshake bundle shared by the arithmetic blocks.
interface cube_if;
  import cube_pkg::*;

  logic          start;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_out;
  logic          busy_o;
  logic          done_o;

  modport master (output start, x_in, input y_out, busy_o, done_o);
  modport slave  (input start, x_in, output y_out, busy_o, done_o);

endinterface

// File: rtl/cube_shift_add_mult.sv
// Shift-add multiplier: one partial product per cycle, fixed ITER cycles,
// single adder into a YW-bit accumulator.
module shift_add_mult
  import cube_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   a,
  input  logic [2*XW-1:0] b,
  output logic [YW-1:0]   product,
  output logic            done
);

  mult_state_t     state;
  logic [XW-1:0]   a_r;
  logic [2*XW-1:0] b_r;
  logic [CW-1:0]   idx;
  logic [YW-1:0]   acc;
  logic [YW-1:0]   addend;

  always_comb begin
    addend = '0;
    if (a_r[idx]) addend = YW'(b_r) << idx;
  end

  assign product = acc;

  // Operands are captured on accept so the caller may change them afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= M_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      acc   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        M_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            idx   <= '0;
            state <= M_RUN;
          end
        end
        M_RUN: begin
          acc <= acc + addend;
          if (idx == CW'(ITER - 1)) begin
            done  <= 1'b1;
            state <= M_IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cube.sv
// Cube generator: y = x*x*x by running the shared multiplier twice.
module cube
  import cube_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  cube_if.slave bus
);

  state_t          state;
  logic [XW-1:0]   x_r;
  logic [2*XW-1:0] sq;
  logic [YW-1:0]   y_r;
  logic            busy_r;
  logic            done_r;
  logic            mult_start;
  logic [2*XW-1:0] mult_b;
  logic [YW-1:0]   product;
  logic            mult_done;

  // Second pass multiplies x by the latched square; first pass squares x.
  assign mult_b = (state == CU) ? sq : {{XW{1'b0}}, x_r};

  shift_add_mult u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (x_r),
    .b       (mult_b),
    .product (product),
    .done    (mult_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      x_r        <= '0;
      sq         <= '0;
      y_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mult_start <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      done_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_r        <= bus.x_in;
            busy_r     <= 1'b1;
            mult_start <= 1'b1;
            state      <= SQ;
          end
        end
        SQ: begin
          if (mult_done) begin
            sq         <= product[2*XW-1:0];
            mult_start <= 1'b1;
            state      <= CU;
          end
        end
        CU: begin
          if (mult_done) begin
            y_r    <= product;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y_out  = y_r;
  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;

endmodule

// File: tb/tb_cube.sv
// Directed self-checking bench for cube: vector table plus multi-cycle sequences.
module tb_cube;
  import cube_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cube_if bus ();

  cube dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present x for exactly the accept edge, then scramble x_in.
  task automatic applyStimulus(input logic [XW-1:0] x);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = x;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = ~x;
  endtask

  // c counts falling edges after the accept edge; done is expected at c = 20.
  task automatic waitResult(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic longint cbrt(input longint y);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
    return r;
  endfunction

  initial begin
    int lat;
    int bc;
    int dcnt;

    vecs[0] = '{x: 8'd0,   y: 24'd0};
    vecs[1] = '{x: 8'd3,   y: 24'd27};
    vecs[2] = '{x: 8'd255, y: 24'd16581375};
    vecs[3] = '{x: 8'd1,   y: 24'd1};
    vecs[4] = '{x: 8'd170, y: 24'd4913000};
    vecs[5] = '{x: 8'd128, y: 24'd2097152};

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_y", bus.y_out, 0);
    checkOutput("reset_busy", bus.busy_o, 0);
    checkOutput("reset_done", bus.done_o, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].x);
      waitResult(lat, bc);
      checkOutput($sformatf("vec%0d_latency", i), lat, 20);
      checkOutput($sformatf("vec%0d_busy_cycles", i), bc, 20);
      checkOutput($sformatf("vec%0d_y", i), bus.y_out, vecs[i].y);
      checkOutput($sformatf("vec%0d_busy_at_done", i), bus.busy_o, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), bus.done_o, 0);
    end

    // Back-to-back with start held high; x_in changes after each accept.
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 8'd5;
    @(posedge clk);
    #1;
    bus.x_in = 8'd6;
    waitResult(lat, bc);
    checkOutput("b2b_first_latency", lat, 20);
    checkOutput("b2b_first_y", bus.y_out, 125);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = 8'd9;
    waitResult(lat, bc);
    checkOutput("b2b_second_latency", lat, 20);
    checkOutput("b2b_second_y", bus.y_out, 216);

    // Starts while busy are ignored and y_out holds the previous result.
    applyStimulus(8'd4);
    lat = -1;
    bc  = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 10) checkOutput("busy_y_held", bus.y_out, 216);
      if (bus.busy_o) bc++;
      if (bus.done_o) begin
        lat = c;
        bus.start = 1'b0;
        break;
      end
      bus.start = (c == 5 || c == 15);
    end
    checkOutput("extra_start_latency", lat, 20);
    checkOutput("extra_start_busy_cycles", bc, 20);
    checkOutput("extra_start_y", bus.y_out, 64);
    dcnt = 0;
    bc   = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done_o) dcnt++;
      if (bus.busy_o) bc++;
    end
    checkOutput("extra_start_no_queue_done", dcnt, 0);
    checkOutput("extra_start_no_queue_busy", bc, 0);

    // Reset sampled at edge 10 of x = 7, then immediate restart with x = 2.
    applyStimulus(8'd7);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", bus.busy_o, 0);
    checkOutput("midreset_y", bus.y_out, 0);
    checkOutput("midreset_done", bus.done_o, 0);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x_in  = 8'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = 8'd7;
    waitResult(lat, bc);
    checkOutput("after_reset_latency", lat, 20);
    checkOutput("after_reset_busy_cycles", bc, 20);
    checkOutput("after_reset_y", bus.y_out, 8);

    // Loopback: the cube of i must invert back to i.
    for (int i = 0; i <= 6; i++) begin
      applyStimulus(XW'(i));
      waitResult(lat, bc);
      checkOutput($sformatf("loop%0d_latency", i), lat, 20);
      checkOutput($sformatf("loop%0d_y", i), bus.y_out, i * i * i);
      checkOutput($sformatf("loop%0d_root", i), cbrt(longint'(bus.y_out)), i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cube.md
# cube

Sequential cube generator: computes y = x³ for an unsigned operand using a single shift-add multiplier run twice (x·x, then (x·x)·x). It is the forward counterpart of the cube-root unit and is used to produce cube-root stimulus and check results in loopback. Handshake: start/busy, the same as every arithmetic block in this design.

## Interface
- XW, default 8: operand width; result width YW = 3·XW, fixed in the package.
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low (rst = 0 resets on the next edge)
- start  in  1  request; sampled only while idle
- x_in  in  XW  operand; sampled only at the accept edge
- y_out  out  YW  result; x_in³, exact with no overflow (255³ = 16581375 < 2²⁴)
- busy_o  out  1  high from the accept edge until the result is written
- done_o  out  1  one-cycle pulse, coincident with the busy_o falling edge

## Operation
- Reset values: y_out = 0, busy_o = 0, done_o = 0, state IDLE, multiplier idle.
- rst has priority over start.
- Controller states:
  - IDLE: start = 1 → latch x, set busy_o = 1, issue multiplier start with (a = x, b = x), go to SQ.
  - SQ: wait for mult done; then latch sq = product[2XW-1:0], issue start with (a = x, b = sq), go to CU.
  - CU: wait for mult done; then y_out ← product, busy_o ← 0, done_o ← 1, go to IDLE.
- Multiplier start is a registered one-cycle pulse.
- Multiplier (shift_add_mult):
  - Fixed 8 iterations (XW); one iteration per cycle, independent of operand values.
  - Each iteration: acc += (a[i] ? b << i : 0), with a 24-bit accumulator and exactly one adder.
  - done pulse is registered on the last iteration edge.
- Latched x and sq are immune to x_in changes during the operation.
- y_out keeps the previous result until it is overwritten in CU; it is never cleared by start.
- start while busy_o = 1 is ignored; it is not queued.

## Timing
- Edge 0 is the accept edge; busy_o is high starting in the cycle after edge 0.
- Multiplier pass 1:
  - Multiplier accepts start at edge 1 and iterates at edges 2–9.
  - done is visible after edge 9 and sampled by the controller at edge 10.
- Multiplier pass 2:
  - Multiplier accepts at edge 11; done is visible after edge 19.
  - At edge 20: y_out written, busy_o → 0, done_o → 1 for one cycle.
- Latency is exactly 20 clocks from accept to result, for every operand (including 0).
- Back-to-back: with start held high, the next accept is edge 21 (IDLE sampled); throughput is 1 result per 21 clocks.
- Reset mid-operation at any edge:
  - busy_o and done_o → 0, y_out → 0, state IDLE.
  - Multiplier aborted; no done_o is produced for the aborted request.
  - A new start is accepted the first edge after rst returns high.

## Structure
- Shared package cube_pkg: XW, YW, the multiplier iteration count, and controller state encodings (IDLE, SQ, CU).
- One sub-module: shift_add_mult, with ports clk, rst, start, a (XW), b (2XW), product (YW), done.
  - Single adder, 24-bit accumulator, iteration counter.
  - Same synchronous active-low reset.
- The controller contains no arithmetic beyond register moves.

## Test plan
- After reset, x = 0, start pulse → busy_o high for exactly 20 cycles; y_out = 0; one done_o pulse.
- x = 3 → y_out = 27 at edge 20. Then x = 255 → y_out = 16581375, latency still 20.
- start held high with x_in = 5, changed to 6 after accept → 125, then 216 accepted at edge 21, done at edge 41. Mid-operation x_in changes have no effect.
- start pulsed at cycles 5 and 15 of an operation on x = 4 → a single result of 64; the extra starts are ignored and busy_o does not extend.
- rst low at edge 10 of x = 7 → busy_o = 0, y_out = 0, no done_o. Then x = 2 → 8 in 20 cycles.
- Loopback for i = 0..6: cube(i) feeds the cube-root unit → returns i; y_out matches i³ every time.
